// File: rtl/need_action_arbiter.sv
// Action sequencer: synchronises and debounces four player inputs, picks one round-robin,
// enforces a per-need hold time and issues a single valid/ready action request per hold.
module need_action_arbiter #(
  parameter int unsigned TICK_DIV  = 7500000,
  parameter int unsigned DEB_TICKS = 2,
  parameter int unsigned HOLD_BTN  = 1,
  parameter int unsigned HOLD_ULT  = 6,
  parameter int unsigned HOLD_GYRO = 12,
  parameter int unsigned HOLD_TEST = 2,
  parameter int unsigned LOCKOUT   = 2
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       btn_salud,
  input  logic       gyro,
  input  logic       btn_ali,
  input  logic       ult,
  input  logic       test_mode,
  input  logic       dead_mode,
  input  logic       act_ready,
  output logic       act_valid,
  output logic [1:0] act_need,
  output logic [1:0] sel_need,
  output logic       busy,
  output logic       tick
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DEB_TICKS > 0) ? $clog2(DEB_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_ISSUE,
    S_LOCKOUT
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic                   tick_q, tick_d;
  logic [3:0]             sync1_q, sync2_q;
  logic [3:0]             deb_q, deb_d;
  logic [3:0][DW-1:0]     deb_cnt_q, deb_cnt_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [1:0]             need_q, need_d;
  logic [7:0]             hold_q, hold_d;
  logic [7:0]             lock_q, lock_d;
  logic                   act_valid_q, act_valid_d;
  logic                   busy_q, busy_d;

  logic [3:0]             raw_req;
  logic [3:0]             req_eff;
  logic                   gnt_found;
  logic [1:0]             gnt_idx;
  logic [7:0]             thr;

  // Bit index equals the need code; all inputs normalised to active-high before sync.
  assign raw_req = {ult, ~btn_ali, ~gyro, ~btn_salud};
  assign req_eff = deb_q & ~{4{dead_mode}};

  assign act_valid = act_valid_q;
  assign act_need  = need_q;
  assign sel_need  = need_q;
  assign busy      = busy_q;
  assign tick      = tick_q;

  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
    tick_d     = (tick_cnt_d == TICK_LAST);
  end

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    if (tick_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (32'(deb_cnt_q[i]) + 32'd1 >= DEB_TICKS) begin
            deb_d[i]     = ~deb_q[i];
            deb_cnt_d[i] = '0;
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
          end
        end else begin
          deb_cnt_d[i] = '0;
        end
      end
    end
  end

  always_comb begin
    logic [1:0] idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!gnt_found && req_eff[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    thr = 8'(HOLD_BTN);
    if (test_mode) begin
      thr = 8'(HOLD_TEST);
    end else begin
      case (need_q)
        2'b01:   thr = 8'(HOLD_GYRO);
        2'b11:   thr = 8'(HOLD_ULT);
        default: thr = 8'(HOLD_BTN);
      endcase
    end
  end

  always_comb begin
    logic [7:0] hold_inc;
    logic [7:0] lock_inc;
    state_d     = state_q;
    need_d      = need_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    lock_d      = lock_q;
    act_valid_d = act_valid_q;
    hold_inc    = hold_q + 8'd1;
    lock_inc    = lock_q + 8'd1;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          need_d  = gnt_idx;
          hold_d  = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // req_eff already carries the dead_mode mask, so this also covers dead entry.
        if (!req_eff[need_q]) begin
          state_d = S_IDLE;
        end else if (tick_q) begin
          hold_d = hold_inc;
          if (hold_inc >= thr) begin
            state_d     = S_ISSUE;
            act_valid_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (act_ready) begin
          act_valid_d = 1'b0;
          ptr_d       = need_q + 2'd1;
          lock_d      = '0;
          state_d     = S_LOCKOUT;
        end else if (dead_mode) begin
          act_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (dead_mode) begin
          state_d = S_IDLE;
        end else if (tick_q) begin
          lock_d = lock_inc;
          if (lock_inc >= 8'(LOCKOUT)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      tick_q      <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_cnt_q   <= '0;
      ptr_q       <= '0;
      need_q      <= '0;
      hold_q      <= '0;
      lock_q      <= '0;
      act_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      tick_q      <= tick_d;
      sync1_q     <= raw_req;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      ptr_q       <= ptr_d;
      need_q      <= need_d;
      hold_q      <= hold_d;
      lock_q      <= lock_d;
      act_valid_q <= act_valid_d;
      busy_q      <= busy_d;
    end
  end

  a_need_stable: assert property (@(posedge clk) disable iff (!btn_reset)
    (act_valid_q && !act_ready) |=> $stable(need_q));

endmodule

// File: tb/tb_need_action_arbiter.sv
// Directed bench for need_action_arbiter with TICK_DIV=4, DEB_TICKS=2; ticks land on every
// 4th rising edge after reset release, so all expected cycle points are fixed numbers.
module tb_need_action_arbiter;

  logic       clk = 1'b0;
  logic       btn_reset, btn_salud, gyro, btn_ali, ult;
  logic       test_mode, dead_mode, act_ready;
  logic       act_valid, busy, tick;
  logic [1:0] act_need, sel_need;

  int errors = 0;
  int checks = 0;
  int ecount = 0;
  int vcount = 0;
  int xcount = 0;
  int vb, xb;

  need_action_arbiter #(
    .TICK_DIV  (4),
    .DEB_TICKS (2)
  ) dut (
    .clk       (clk),
    .btn_reset (btn_reset),
    .btn_salud (btn_salud),
    .gyro      (gyro),
    .btn_ali   (btn_ali),
    .ult       (ult),
    .test_mode (test_mode),
    .dead_mode (dead_mode),
    .act_ready (act_ready),
    .act_valid (act_valid),
    .act_need  (act_need),
    .sel_need  (sel_need),
    .busy      (busy),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release: edge k is a tick edge when k is a multiple of 4.
  always @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) ecount <= 0;
    else            ecount <= ecount + 1;
  end

  always @(posedge clk) begin
    if (act_valid)              vcount <= vcount + 1;
    if (act_valid && act_ready) xcount <= xcount + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int k);
    while (ecount < k) @(negedge clk);
  endtask

  task automatic idle_inputs();
    btn_salud = 1'b1; gyro = 1'b1; btn_ali = 1'b1; ult = 1'b0;
    test_mode = 1'b0; dead_mode = 1'b0; act_ready = 1'b1;
  endtask

  task automatic do_reset();
    btn_reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    btn_reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    btn_reset = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_valid", 8'(act_valid), 8'd0);
    check("rst_busy",  8'(busy),      8'd0);
    check("rst_sel",   8'(sel_need),  8'd0);
    check("rst_need",  8'(act_need),  8'd0);
    check("rst_tick",  8'(tick),      8'd0);
    btn_reset = 1'b1;

    // T1: hambre issues, re-granted, reset mid-HOLD, pointer back to 00
    wait_to(1);  btn_ali = 1'b0;
    wait_to(8);  check("t1_busy_pre", 8'(busy), 8'd0);
    wait_to(9);  check("t1_busy", 8'(busy), 8'd1);
                 check("t1_sel", 8'(sel_need), 8'd2);
    wait_to(12); check("t1_valid", 8'(act_valid), 8'd1);
                 check("t1_need", 8'(act_need), 8'd2);
    wait_to(13); check("t1_valid_drop", 8'(act_valid), 8'd0);
    wait_to(21); check("t1_regrant", 8'(busy), 8'd1);
    wait_to(22); btn_reset = 1'b0; btn_ali = 1'b1;
    @(negedge clk);
    check("t1_rst_valid", 8'(act_valid), 8'd0);
    check("t1_rst_busy",  8'(busy),      8'd0);
    check("t1_rst_sel",   8'(sel_need),  8'd0);
    check("t1_rst_need",  8'(act_need),  8'd0);
    @(negedge clk); btn_reset = 1'b1;
    wait_to(1);  btn_ali = 1'b0; ult = 1'b1;
    wait_to(9);  check("t1_ptr_sel", 8'(sel_need), 8'd2);

    // T2: salud held, repeats every 3 ticks
    do_reset();
    wait_to(1);  btn_salud = 1'b0;
    wait_to(9);  check("t2_sel", 8'(sel_need), 8'd0);
                 check("t2_busy", 8'(busy), 8'd1);
    wait_to(11); check("t2_valid_pre", 8'(act_valid), 8'd0);
                 check("t2_tick_hi", 8'(tick), 8'd1);
    wait_to(12); check("t2_valid1", 8'(act_valid), 8'd1);
                 check("t2_need1", 8'(act_need), 8'd0);
                 check("t2_tick_lo", 8'(tick), 8'd0);
    wait_to(13); check("t2_valid1_drop", 8'(act_valid), 8'd0);
                 check("t2_busy_lock", 8'(busy), 8'd1);
    wait_to(23); check("t2_valid2_pre", 8'(act_valid), 8'd0);
    wait_to(24); check("t2_valid2", 8'(act_valid), 8'd1);
    wait_to(25); check("t2_valid2_drop", 8'(act_valid), 8'd0);
    wait_to(35); check("t2_valid3_pre", 8'(act_valid), 8'd0);
    wait_to(36); check("t2_valid3", 8'(act_valid), 8'd1);
    btn_salud = 1'b1;

    // T3: gyro abort, then T4: fairness from unchanged pointer 00
    do_reset();
    wait_to(1);  gyro = 1'b0;
    wait_to(9);  check("t3_sel", 8'(sel_need), 8'd1);
                 check("t3_busy", 8'(busy), 8'd1);
                 vb = vcount;
    wait_to(33); gyro = 1'b1;
    wait_to(40); check("t3_busy_hold", 8'(busy), 8'd1);
    wait_to(41); check("t3_busy_idle", 8'(busy), 8'd0);
                 check("t3_sel_kept", 8'(sel_need), 8'd1);
                 check("t3_no_valid", 8'(vcount - vb), 8'd0);
    wait_to(44); btn_salud = 1'b0; btn_ali = 1'b0; ult = 1'b1;
    wait_to(53); check("t4_first_sel", 8'(sel_need), 8'd0);
    wait_to(56); check("t4_v1", 8'(act_valid), 8'd1);
                 check("t4_n1", 8'(act_need), 8'd0);
    wait_to(68); check("t4_v2", 8'(act_valid), 8'd1);
                 check("t4_n2", 8'(act_need), 8'd2);
    wait_to(99); check("t4_v3_pre", 8'(act_valid), 8'd0);
    wait_to(100);check("t4_v3", 8'(act_valid), 8'd1);
                 check("t4_n3", 8'(act_need), 8'd3);
    wait_to(112);check("t4_v4", 8'(act_valid), 8'd1);
                 check("t4_n4", 8'(act_need), 8'd0);

    // T5: backpressure for 20 cycles, then a single transfer
    do_reset();
    act_ready = 1'b0;
    wait_to(1);  btn_salud = 1'b0;
    wait_to(12); check("t5_valid", 8'(act_valid), 8'd1);
                 check("t5_need", 8'(act_need), 8'd0);
                 xb = xcount;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t5_valid_held", 8'(act_valid), 8'd1);
      check("t5_need_held", 8'(act_need), 8'd0);
    end
    act_ready = 1'b1; btn_salud = 1'b1;
    wait_to(33); check("t5_valid_drop", 8'(act_valid), 8'd0);
    wait_to(60); check("t5_one_xfer", 8'(xcount - xb), 8'd1);
                 check("t5_idle", 8'(busy), 8'd0);

    // T6: test_mode shortens ult hold, dead_mode cancels ISSUE and masks requests
    do_reset();
    act_ready = 1'b0; test_mode = 1'b1;
    wait_to(1);  ult = 1'b1;
    wait_to(9);  check("t6_sel", 8'(sel_need), 8'd3);
    wait_to(15); check("t6_valid_pre", 8'(act_valid), 8'd0);
    wait_to(16); check("t6_valid", 8'(act_valid), 8'd1);
                 check("t6_need", 8'(act_need), 8'd3);
    wait_to(18); dead_mode = 1'b1;
    wait_to(19); check("t6_dead_valid", 8'(act_valid), 8'd0);
                 check("t6_dead_busy", 8'(busy), 8'd0);
                 check("t6_dead_sel", 8'(sel_need), 8'd3);
                 vb = vcount;
    wait_to(40); check("t6_dead_no_valid", 8'(vcount - vb), 8'd0);
                 check("t6_dead_idle", 8'(busy), 8'd0);
                 dead_mode = 1'b0;
    wait_to(41); check("t6_alive_grant", 8'(busy), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
